// File: rtl/sd_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pio_pkg
// Description : Register addresses and edge-type selectors for sd_pio_in_irq.
// Revision    : 1.0
// ============================================================================
package sd_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_DBTH = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/sd_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sd_pio_debounce
// Description : One channel: two-flop synchroniser, threshold debouncer and
//               edge detector on the debounced value.
// Revision    : 1.0
// ============================================================================
module sd_pio_debounce
    import sd_pio_pkg::*;
#(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            din,
    input  logic [DB_W-1:0] thresh,
    output logic            dout,
    output logic            rise,
    output logic            fall
);

    logic            s1_q;
    logic            s2_q;
    logic            db_q;
    logic            db_d;
    logic            db_prev_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // The counter only runs while the synchronised input disagrees with db;
    // reaching the threshold commits the new level and restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q >= thresh) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= din;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign dout = db_q;
    assign rise = db_q & ~db_prev_q;
    assign fall = ~db_q & db_prev_q;

endmodule
`default_nettype wire

// File: rtl/sd_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : sd_pio_in_irq
// Description : Avalon-MM input PIO with debounce, edge capture and masked
//               level interrupt for SD-card status lines.
// Revision    : 1.0
// ============================================================================
module sd_pio_in_irq
    import sd_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 0,
    parameter int BIT_CLEAR = 1,
    parameter int DB_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] clr;
    logic             wr;

    logic [DB_W-1:0]  db_thresh_q;
    logic [DB_W-1:0]  db_thresh_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic             irq_q;
    logic             irq_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sd_pio_debounce #(
            .DB_W (DB_W)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .thresh  (db_thresh_q),
            .dout    (db[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign wr = chipselect & ~write_n;

    always_comb begin
        sel = rise;
        case (EDGE_TYPE)
            EDGE_FALL: sel = fall;
            EDGE_ANY:  sel = rise | fall;
            default:   sel = rise;
        endcase
    end

    always_comb begin
        db_thresh_d = db_thresh_q;
        irqmask_d   = irqmask_q;
        clr         = '0;
        if (wr) begin
            case (pio_addr_e'(address))
                ADDR_DBTH: db_thresh_d = writedata[DB_W-1:0];
                ADDR_MASK: irqmask_d   = writedata[WIDTH-1:0];
                ADDR_EDGE: clr         = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
                default:   ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~clr) | sel;
        irq_d     = |(edgecap_d & irqmask_d);
    end

    always_comb begin
        readdata_d = '0;
        case (pio_addr_e'(address))
            ADDR_DATA: readdata_d[WIDTH-1:0] = db;
            ADDR_DBTH: readdata_d[DB_W-1:0]  = db_thresh_q;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_thresh_q <= '0;
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            irq_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            db_thresh_q <= db_thresh_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            irq_q       <= irq_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_pio_in_irq
// Description : Self-checking bench; three builds (rise/bit-clear,
//               any/clear-all, fall/bit-clear) share one bus and input bundle.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sd_pio_in_irq;
    import sd_pio_pkg::*;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic [31:0] writedata  = 32'd0;
    logic [3:0]  in_port    = 4'd0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  pin;
        logic [31:0] data;
        logic [31:0] ec0;
        logic [31:0] ec1;
        logic [31:0] ec2;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    sd_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(0), .BIT_CLEAR(1), .DB_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    sd_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(2), .BIT_CLEAR(0), .DB_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    sd_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(1), .BIT_CLEAR(1), .DB_W(16)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    function automatic logic [31:0] rdsel(input int d);
        case (d)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        address = a;
        tick();
        check(nm, rdsel(d), exp_q.pop_front());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{pin: 4'h0, data: 32'h0, ec0: 32'h0, ec1: 32'h5, ec2: 32'h5};
        vecs[1] = '{pin: 4'hA, data: 32'hA, ec0: 32'hA, ec1: 32'hA, ec2: 32'h0};
        vecs[2] = '{pin: 4'h3, data: 32'h3, ec0: 32'h1, ec1: 32'h9, ec2: 32'h8};
        vecs[3] = '{pin: 4'hC, data: 32'hC, ec0: 32'hC, ec1: 32'hF, ec2: 32'h3};

        ticks(3);
        check("reset_rd", rd0, 32'h0);
        check("reset_irq", {31'd0, irq0}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(0, 2'(a), 32'h0, $sformatf("reset_addr%0d", a));
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd(0, ADDR_DATA, 32'h0, "data_ro");
        rd(0, ADDR_DBTH, 32'h0, "data_ro_thresh");

        // thresh 0: pin to db takes three edges, readdata one more
        in_port = 4'h5;
        address = ADDR_DATA;
        ticks(3);
        check("lat_edge3", rd0, 32'h0);
        tick();
        check("lat_edge4", rd0, 32'h5);
        rd(0, ADDR_EDGE, 32'h5, "ec_rise");
        rd(1, ADDR_EDGE, 32'h5, "ec_any");
        rd(2, ADDR_EDGE, 32'h0, "ec_fall");
        check("irq_unmasked", {31'd0, irq0}, 32'h0);

        wr(ADDR_MASK, 32'h4);
        check("irq_mask0", {31'd0, irq0}, 32'h1);
        check("irq_mask1", {31'd0, irq1}, 32'h1);
        check("irq_mask2", {31'd0, irq2}, 32'h0);

        wr(ADDR_EDGE, 32'h1);
        check("irq_bitclr0", {31'd0, irq0}, 32'h1);
        check("irq_allclr1", {31'd0, irq1}, 32'h0);
        rd(0, ADDR_EDGE, 32'h4, "ec_bitclr");
        rd(1, ADDR_EDGE, 32'h0, "ec_allclr");
        wr(ADDR_EDGE, 32'h4);
        check("irq_cleared", {31'd0, irq0}, 32'h0);
        rd(0, ADDR_EDGE, 32'h0, "ec_cleared");

        for (int i = 0; i < 4; i++) begin
            in_port = vecs[i].pin;
            ticks(6);
            rd(0, ADDR_DATA, vecs[i].data, $sformatf("tbl%0d_data", i));
            rd(0, ADDR_EDGE, vecs[i].ec0, $sformatf("tbl%0d_ec_rise", i));
            rd(1, ADDR_EDGE, vecs[i].ec1, $sformatf("tbl%0d_ec_any", i));
            rd(2, ADDR_EDGE, vecs[i].ec2, $sformatf("tbl%0d_ec_fall", i));
            wr(ADDR_EDGE, 32'hF);
        end

        // debounce threshold 10: short glitch rejected, long hold committed
        wr(ADDR_DBTH, 32'd10);
        rd(0, ADDR_DBTH, 32'd10, "thresh_rd");
        in_port = 4'hE;
        ticks(8);
        in_port = 4'hC;
        ticks(20);
        rd(0, ADDR_DATA, 32'hC, "glitch_data");
        rd(0, ADDR_EDGE, 32'h0, "glitch_ec");
        in_port = 4'hE;
        address = ADDR_DATA;
        ticks(13);
        check("hold_edge13", rd0, 32'hC);
        tick();
        check("hold_edge14", rd0, 32'hE);
        rd(0, ADDR_EDGE, 32'h2, "hold_ec");
        check("hold_irq", {31'd0, irq0}, 32'h0);
        wr(ADDR_EDGE, 32'hF);

        // clear and new rise on bit0 land on the same edge
        wr(ADDR_DBTH, 32'd0);
        wr(ADDR_MASK, 32'h1);
        in_port = 4'hF;
        ticks(3);
        wr(ADDR_EDGE, 32'h1);
        check("race_irq", {31'd0, irq0}, 32'h1);
        rd(0, ADDR_EDGE, 32'h1, "race_ec");

        // asynchronous reset during a count
        wr(ADDR_DBTH, 32'd10);
        in_port = 4'h0;
        ticks(6);
        address = ADDR_EDGE;
        tick();
        check("pre_reset_rd", rd0, 32'h1);
        check("pre_reset_irq", {31'd0, irq0}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", rd0, 32'h0);
        check("async_rst_irq", {31'd0, irq0}, 32'h0);
        in_port = 4'hF;
        ticks(2);
        reset_n = 1'b1;
        rd(0, ADDR_DBTH, 32'h0, "post_rst_thresh");
        rd(0, ADDR_MASK, 32'h0, "post_rst_mask");
        ticks(4);
        rd(0, ADDR_EDGE, 32'hF, "post_rst_ec");
        check("post_rst_irq", {31'd0, irq0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
